// File: rtl/instr_pack.sv
// Shared decode/sequencing types for the load/store path between the
// register file and the data memory port.
package instr_pack;

    typedef enum logic [1:0] {
        LS_IDLE = 2'd0,
        LS_REQ  = 2'd1,
        LS_WAIT = 2'd2,
        LS_WB   = 2'd3
    } ldst_state;

    localparam int LDST_TIMEOUT_DEF = 16;
    localparam int LDST_DATA_W      = 8;
    localparam int LDST_REG_W       = 4;

    typedef struct packed {
        logic                   is_store;
        logic [LDST_REG_W-1:0]  dst;
        logic [LDST_DATA_W-1:0] wdata;
    } ldst_op_t;

    // Last counter value before abort; out-of-range settings are clamped to 1..255.
    function automatic logic [7:0] ldst_wd_limit(input int cycles);
        logic [7:0] lim;
        if (cycles < 1) begin
            lim = 8'd0;
        end else if (cycles > 255) begin
            lim = 8'd254;
        end else begin
            lim = 8'(cycles - 1);
        end
        return lim;
    endfunction

endpackage

// File: rtl/ldst_watchdog.sv
// Access watchdog: counts cycles spent waiting on the memory and flags the
// cycle on which the allowance runs out.
module ldst_watchdog
    import instr_pack::*;
#(
    parameter int TIMEOUT_CYCLES = LDST_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = ldst_wd_limit(TIMEOUT_CYCLES);

    logic [7:0] cnt_r;

    // Wait-cycle counter; clear has priority so the entry cycle into WAIT restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry is flagged during the last allowed cycle so the FSM can still let gnt/rvalid win.
    always_comb begin
        expired = en & (cnt_r == LIMIT);
    end

endmodule

// File: rtl/ldst_sequencer.sv
// Load/store sequencer: captures a decoded memory op, runs it over the
// req/gnt + rvalid memory handshake and writes load data back to the register file.
module ldst_sequencer
    import instr_pack::*;
#(
    parameter int TIMEOUT_CYCLES = LDST_TIMEOUT_DEF,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_is_store,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [3:0]        op_dst,
    input  logic [7:0]        stor_data,
    output logic              storEn,
    output logic              stall,
    output logic              loadEn,
    output logic [3:0]        load_dst,
    output logic [7:0]        loadData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              err_timeout
);

    ldst_state         state_r;
    ldst_state         state_nxt_s;
    ldst_op_t          op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        rdata_r;
    logic              err_r;
    logic              capture_s;
    logic              wd_clr_s;
    logic              wd_en_s;
    logic              wd_expired_s;
    logic              abort_s;

    assign capture_s = (state_r == LS_IDLE) & op_valid;
    assign wd_en_s   = (state_r == LS_REQ) | (state_r == LS_WAIT);
    assign wd_clr_s  = capture_s | ((state_r == LS_REQ) & mem_gnt);
    // A handshake on the expiry cycle takes priority over the abort.
    assign abort_s   = wd_expired_s &
                       (((state_r == LS_REQ) & ~mem_gnt) | ((state_r == LS_WAIT) & ~mem_rvalid));
    assign err_timeout = err_r;

    ldst_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expired(wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LS_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LS_IDLE: begin
                if (op_valid) begin
                    state_nxt_s = LS_REQ;
                end else begin
                    state_nxt_s = LS_IDLE;
                end
            end
            LS_REQ: begin
                if (mem_gnt) begin
                    state_nxt_s = op_r.is_store ? LS_IDLE : LS_WAIT;
                end else if (wd_expired_s) begin
                    state_nxt_s = LS_IDLE;
                end else begin
                    state_nxt_s = LS_REQ;
                end
            end
            LS_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = LS_WB;
                end else if (wd_expired_s) begin
                    state_nxt_s = LS_IDLE;
                end else begin
                    state_nxt_s = LS_WAIT;
                end
            end
            LS_WB: begin
                state_nxt_s = LS_IDLE;
            end
            default: begin
                state_nxt_s = LS_IDLE;
            end
        endcase
    end

    // Op capture in IDLE and read-data capture in WAIT; ops seen elsewhere are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '{is_store: 1'b0, dst: 4'h0, wdata: 8'h00};
            addr_r  <= {ADDR_W{1'b0}};
            rdata_r <= 8'h00;
        end else begin
            if (capture_s) begin
                op_r.is_store <= op_is_store;
                op_r.dst      <= op_dst;
                op_r.wdata    <= op_is_store ? stor_data : 8'h00;
                addr_r        <= op_addr;
            end else begin
                op_r   <= op_r;
                addr_r <= addr_r;
            end
            if ((state_r == LS_WAIT) & mem_rvalid) begin
                rdata_r <= mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (abort_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Output decode; the IDLE handshake terms are forced low while reset is held.
    always_comb begin
        storEn    = 1'b0;
        stall     = 1'b0;
        loadEn    = 1'b0;
        load_dst  = 4'h0;
        loadData  = 8'h00;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 8'h00;
        case (state_r)
            LS_IDLE: begin
                storEn = op_valid & op_is_store & ~reset;
                stall  = op_valid & ~reset;
            end
            LS_REQ: begin
                mem_req   = 1'b1;
                mem_we    = op_r.is_store;
                mem_addr  = addr_r;
                mem_wdata = op_r.wdata;
                stall     = 1'b1;
            end
            LS_WAIT: begin
                stall = 1'b1;
            end
            LS_WB: begin
                loadEn   = 1'b1;
                load_dst = op_r.dst;
                loadData = rdata_r;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
